ucode_seq_2addr: RTL and testbench
==================================

# ucode_seq_2addr

Parametrised two-address microcode sequencer: an internal writable microcode store, an N-way condition multiplexer with polarity control, and a microprogram counter (uPC) that steps each enabled cycle to the word's NST (next-state-true) or NSF (next-state-false) address. It replaces the fixed 4-input condition select used by the control unit. It sits between datapath status flags (conditions in) and datapath control strobes (ctrl_out). Start/done handshaking lets an outer controller launch microprograms.

## Interface
- COND_N, default 7: number of external condition inputs. Condition index COND_N is an internal constant 1, used for unconditional jumps.
- SEL_W, default 3: select field width. Must satisfy 2**SEL_W >= COND_N+1.
- ADDR_W, default 4: uPC / microcode address width. DEPTH = 2**ADDR_W words.
- OUT_W, default 8: control strobe width.
- Microword MW = 1+OUT_W+1+SEL_W+2*ADDR_W bits (21 at defaults), MSB to LSB: fin, ctrl[OUT_W], inv, sel[SEL_W], nst[ADDR_W], nsf[ADDR_W].

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launch request, sampled in IDLE.
- step_en  in  1  advance permission while RUN.
- cond  in  COND_N  condition flags; bit i is condition index i.
- prog_we  in  1  microcode write strobe.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  MW  write data.
- ctrl_out  out  OUT_W  ctrl field of the current word in RUN, else 0.
- upc  out  ADDR_W  current microprogram address.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after a fin word retires.
- taken  out  1  evaluated branch condition of the current word (0 in IDLE).

## Operation
- Reset: upc=0, state IDLE, busy=0, done=0, ctrl_out=0, taken=0. All microcode words are cleared to 0.
- Condition evaluation (combinational, current word w=mem[upc]):
  - c_raw = cond[w.sel] if w.sel < COND_N.
  - c_raw = 1 if w.sel >= COND_N.
  - taken = c_raw XOR w.inv.
- FSM states:
  - IDLE: upc held at 0. ctrl_out=0. A start=1 at an edge goes to RUN with upc=0.
  - RUN, step_en=0: hold upc and the state.
  - RUN, step_en=1, w.fin=0: upc <= taken ? w.nst : w.nsf.
  - RUN, step_en=1, w.fin=1: go to IDLE, upc <= 0, done <= 1 for exactly one cycle. nst/nsf are ignored.
- start while in RUN is ignored. start is level-sampled; a held start relaunches on the cycle after done.
- Programming is permitted in any state. mem[prog_addr] <= prog_data at the edge.
  - A write to the current upc in the same cycle as a step: the step uses the old word; the new word is visible from the next cycle.
- Self-loop words (nst=nsf=own address, fin=0) spin until reset. This is legal.
- All address arithmetic is within ADDR_W. No increment exists; every next address is explicit.

## Timing
- ctrl_out, taken and the fields of w are combinational from upc and the memory. They are valid in the same cycle as upc.
- start at edge k: busy=1 and ctrl_out=mem[0].ctrl from cycle k+1.
- Each enabled step has 1-cycle latency from the condition sample to the new upc.
- The fin word retires at edge k: busy=0 and done=1 during cycle k+1; done=0 at cycle k+2.
- Conditions are sampled only at edges where step_en=1. Conditions must be synchronous to clk.
- Asynchronous reset mid-RUN forces IDLE immediately. No done pulse is produced, and the memory is cleared.

## Test plan
- Reset, then idle:
  - Check outputs after rst_n release: upc=0, busy=0, done=0, ctrl_out=0, taken=0.
  - start=0 for 5 cycles: nothing changes.
- Branch both ways:
  - Program w0 = {fin0, ctrl 0x11, inv0, sel2, nst5, nsf9}, w5 = {fin1, ctrl 0xA5, ...}, w9 = {fin1, ctrl 0x3C, ...}.
  - With cond[2]=1: start gives upc 0→5, ctrl_out 0x11→0xA5, then a done pulse.
  - Repeat with cond[2]=0: path is 0→9 with ctrl_out 0x3C.
- Inversion and constant select:
  - w0 sel=7 (COND_N), inv=0 always goes to nst. inv=1 always goes to nsf, regardless of cond.
- Stall: step_en=0 for 4 cycles in RUN. upc and ctrl_out hold; the step resumes on the first cycle step_en=1.
- Write hazard: in RUN at upc=3, write mem[3] with nsf changed, in the same cycle as the step. The step follows the old nsf; a revisit of 3 uses the new word.
- Reset mid-run: assert rst_n=0 while busy at upc=6. Immediately upc=0, busy=0, no done pulse, and a readback run shows the memory cleared (self-loop at 0).

Source files
------------

// File: rtl/ucode_seq_2addr.sv
// Two-address microcode sequencer: writable microcode store, condition mux with
// polarity control, and a uPC that steps to an explicit NST/NSF address each
// enabled cycle. Start/done handshake lets an outer controller launch programs.
// Microword layout, MSB to LSB: fin, ctrl[OUT_W], inv, sel[SEL_W], nst, nsf.
module ucode_seq_2addr #(
  parameter int unsigned COND_N = 7,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned OUT_W  = 8,
  localparam int unsigned MW    = 1 + OUT_W + 1 + SEL_W + 2 * ADDR_W,
  localparam int unsigned DEPTH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step_en,
  input  logic [COND_N-1:0] cond,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [MW-1:0]     prog_data,
  output logic [OUT_W-1:0]  ctrl_out,
  output logic [ADDR_W-1:0] upc,
  output logic              busy,
  output logic              done,
  output logic              taken
);

  // Field bit positions within a microword.
  localparam int unsigned NsfLo  = 0;
  localparam int unsigned NstLo  = ADDR_W;
  localparam int unsigned SelLo  = 2 * ADDR_W;
  localparam int unsigned InvBit = SelLo + SEL_W;
  localparam int unsigned CtrlLo = InvBit + 1;
  localparam int unsigned FinBit = CtrlLo + OUT_W;
  localparam int unsigned CondW  = 2 ** SEL_W;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   upc_q, upc_d;
  logic                done_q, done_d;
  logic [MW-1:0]       mem_q [DEPTH];

  // Decoded fields of the word at the current uPC.
  logic [MW-1:0]       word;
  logic                w_fin;
  logic [OUT_W-1:0]    w_ctrl;
  logic                w_inv;
  logic [SEL_W-1:0]    w_sel;
  logic [ADDR_W-1:0]   w_nst;
  logic [ADDR_W-1:0]   w_nsf;
  logic [CondW-1:0]    cond_ext;
  logic                c_raw;
  logic                branch;

  // Microcode store: cleared by reset, writable in any state. A write to the
  // current uPC lands at the edge, so a simultaneous step still sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Word fetch, field decode and condition evaluation.
  always_comb begin
    word   = mem_q[upc_q];
    w_fin  = word[FinBit];
    w_ctrl = word[CtrlLo +: OUT_W];
    w_inv  = word[InvBit];
    w_sel  = word[SelLo +: SEL_W];
    w_nst  = word[NstLo +: ADDR_W];
    w_nsf  = word[NsfLo +: ADDR_W];
    // Selects at or above COND_N read a constant 1 (unconditional branch).
    cond_ext               = '1;
    cond_ext[COND_N-1:0]   = cond;
    c_raw                  = cond_ext[w_sel];
    branch                 = c_raw ^ w_inv;
  end

  // Sequencer state, uPC and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      upc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: launch from idle, step or retire while running.
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        upc_d = '0;
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (step_en) begin
          if (w_fin) begin
            // nst/nsf of a fin word are ignored.
            state_d = StIdle;
            upc_d   = '0;
            done_d  = 1'b1;
          end else begin
            upc_d = branch ? w_nst : w_nsf;
          end
        end
      end
      default: begin
        state_d = StIdle;
        upc_d   = '0;
      end
    endcase
  end

  // Outputs: strobes and branch flag are only meaningful while running.
  always_comb begin
    busy     = (state_q == StRun);
    upc      = upc_q;
    done     = done_q;
    ctrl_out = busy ? w_ctrl : '0;
    taken    = busy ? branch : 1'b0;
  end

endmodule

// File: tb/tb_ucode_seq_2addr.sv
// Directed bench for ucode_seq_2addr: a vector table for branch, inversion,
// constant-select and relaunch behaviour, plus hand sequences for stall,
// write hazard and reset mid-run.
module tb_ucode_seq_2addr;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        step_en;
  logic [6:0]  cond;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [20:0] prog_data;
  logic [7:0]  ctrl_out;
  logic [3:0]  upc;
  logic        busy;
  logic        done;
  logic        taken;

  int checks = 0;
  int errors = 0;

  ucode_seq_2addr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .step_en   (step_en),
    .cond      (cond),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ctrl_out  (ctrl_out),
    .upc       (upc),
    .busy      (busy),
    .done      (done),
    .taken     (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        step_en;
    logic [6:0]  cond;
    logic        we;
    logic [3:0]  addr;
    logic [20:0] data;
    logic [3:0]  e_upc;
    logic        e_busy;
    logic        e_done;
    logic [7:0]  e_ctrl;
    logic        e_taken;
  } vec_t;

  vec_t tbl [22];

  function automatic logic [20:0] mk(input logic fin, input logic [7:0] ctrl, input logic inv,
                                     input logic [2:0] sel, input logic [3:0] nst,
                                     input logic [3:0] nsf);
    return {fin, ctrl, inv, sel, nst, nsf};
  endfunction

  function automatic vec_t v(input logic st, input logic se, input logic [6:0] c,
                             input logic we, input logic [3:0] a, input logic [20:0] d,
                             input logic [3:0] eu, input logic eb, input logic ed,
                             input logic [7:0] ec, input logic et);
    vec_t r;
    r.start = st; r.step_en = se; r.cond = c; r.we = we; r.addr = a; r.data = d;
    r.e_upc = eu; r.e_busy = eb; r.e_done = ed; r.e_ctrl = ec; r.e_taken = et;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eu, input logic eb,
                         input logic ed, input logic [7:0] ec, input logic et);
    chk({tag, " upc"},   32'(upc),      32'(eu));
    chk({tag, " busy"},  32'(busy),     32'(eb));
    chk({tag, " done"},  32'(done),     32'(ed));
    chk({tag, " ctrl"},  32'(ctrl_out), 32'(ec));
    chk({tag, " taken"}, 32'(taken),    32'(et));
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [3:0] a, input logic [20:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    cyc();
    prog_we = 1'b0;
  endtask

  logic [20:0] w0a, w5, w9, w0b, w0c;

  initial begin
    rst_n = 1'b0; start = 1'b0; step_en = 1'b0; cond = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    w0a = mk(1'b0, 8'h11, 1'b0, 3'd2, 4'd5, 4'd9);
    w5  = mk(1'b1, 8'hA5, 1'b0, 3'd7, 4'd0, 4'd0);
    w9  = mk(1'b1, 8'h3C, 1'b0, 3'd7, 4'd0, 4'd0);
    w0b = mk(1'b0, 8'h22, 1'b0, 3'd7, 4'd5, 4'd9);
    w0c = mk(1'b0, 8'h33, 1'b1, 3'd7, 4'd5, 4'd9);

    //            st se cond   we addr data | upc busy done ctrl  taken
    tbl[0]  = v(0, 0, 7'h00, 1, 4'd0, w0a, 4'd0, 0, 0, 8'h00, 0);
    tbl[1]  = v(0, 0, 7'h00, 1, 4'd5, w5,  4'd0, 0, 0, 8'h00, 0);
    tbl[2]  = v(0, 0, 7'h00, 1, 4'd9, w9,  4'd0, 0, 0, 8'h00, 0);
    tbl[3]  = v(1, 0, 7'h04, 0, 4'd0, '0,  4'd0, 1, 0, 8'h11, 1);
    tbl[4]  = v(0, 1, 7'h04, 0, 4'd0, '0,  4'd5, 1, 0, 8'hA5, 1);
    tbl[5]  = v(0, 1, 7'h04, 0, 4'd0, '0,  4'd0, 0, 1, 8'h00, 0);
    tbl[6]  = v(0, 0, 7'h00, 0, 4'd0, '0,  4'd0, 0, 0, 8'h00, 0);
    tbl[7]  = v(1, 0, 7'h00, 0, 4'd0, '0,  4'd0, 1, 0, 8'h11, 0);
    tbl[8]  = v(0, 1, 7'h00, 0, 4'd0, '0,  4'd9, 1, 0, 8'h3C, 1);
    tbl[9]  = v(0, 1, 7'h00, 0, 4'd0, '0,  4'd0, 0, 1, 8'h00, 0);
    tbl[10] = v(0, 0, 7'h00, 1, 4'd0, w0b, 4'd0, 0, 0, 8'h00, 0);
    tbl[11] = v(1, 0, 7'h7F, 0, 4'd0, '0,  4'd0, 1, 0, 8'h22, 1);
    tbl[12] = v(0, 1, 7'h00, 0, 4'd0, '0,  4'd5, 1, 0, 8'hA5, 1);
    tbl[13] = v(0, 1, 7'h00, 0, 4'd0, '0,  4'd0, 0, 1, 8'h00, 0);
    tbl[14] = v(0, 0, 7'h7F, 1, 4'd0, w0c, 4'd0, 0, 0, 8'h00, 0);
    tbl[15] = v(1, 0, 7'h7F, 0, 4'd0, '0,  4'd0, 1, 0, 8'h33, 0);
    tbl[16] = v(0, 1, 7'h7F, 0, 4'd0, '0,  4'd9, 1, 0, 8'h3C, 1);
    tbl[17] = v(1, 1, 7'h7F, 0, 4'd0, '0,  4'd0, 0, 1, 8'h00, 0);
    tbl[18] = v(1, 0, 7'h7F, 0, 4'd0, '0,  4'd0, 1, 0, 8'h33, 0);
    tbl[19] = v(0, 1, 7'h00, 0, 4'd0, '0,  4'd9, 1, 0, 8'h3C, 1);
    tbl[20] = v(0, 1, 7'h00, 0, 4'd0, '0,  4'd0, 0, 1, 8'h00, 0);
    tbl[21] = v(0, 0, 7'h00, 0, 4'd0, '0,  4'd0, 0, 0, 8'h00, 0);

    // Reset and idle.
    #12;
    rst_n = 1'b1;
    #1;
    chk_out("reset", 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_out($sformatf("idle%0d", i), 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    end

    // Vector table.
    for (int i = 0; i < 22; i++) begin
      start     = tbl[i].start;
      step_en   = tbl[i].step_en;
      cond      = tbl[i].cond;
      prog_we   = tbl[i].we;
      prog_addr = tbl[i].addr;
      prog_data = tbl[i].data;
      cyc();
      chk_out($sformatf("row%0d", i), tbl[i].e_upc, tbl[i].e_busy, tbl[i].e_done,
              tbl[i].e_ctrl, tbl[i].e_taken);
    end
    start = 1'b0; step_en = 1'b0; prog_we = 1'b0; cond = '0;

    // Program: 0 -> 3 -> (nsf) 8 -> 3 -> (new nsf) 10 -> 6 spin.
    prog(4'd0,  mk(1'b0, 8'h01, 1'b0, 3'd7, 4'd3, 4'd0));
    prog(4'd3,  mk(1'b0, 8'h03, 1'b0, 3'd0, 4'd6, 4'd8));
    prog(4'd8,  mk(1'b0, 8'h08, 1'b0, 3'd7, 4'd3, 4'd3));
    prog(4'd10, mk(1'b0, 8'h0A, 1'b0, 3'd7, 4'd6, 4'd6));
    prog(4'd6,  mk(1'b0, 8'h06, 1'b0, 3'd7, 4'd6, 4'd6));

    // Stall at upc 0 for 4 cycles, then resume.
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_out("launch", 4'd0, 1'b1, 1'b0, 8'h01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_out($sformatf("stall%0d", i), 4'd0, 1'b1, 1'b0, 8'h01, 1'b1);
    end
    step_en = 1'b1;
    cyc();
    chk_out("resume", 4'd3, 1'b1, 1'b0, 8'h03, 1'b0);

    // Rewrite word 3 in the same cycle it steps: old nsf (8) is followed.
    prog_we = 1'b1; prog_addr = 4'd3; prog_data = mk(1'b0, 8'h0C, 1'b0, 3'd0, 4'd6, 4'd10);
    cyc();
    prog_we = 1'b0;
    chk_out("hazard step", 4'd8, 1'b1, 1'b0, 8'h08, 1'b1);
    cyc();
    chk_out("revisit3", 4'd3, 1'b1, 1'b0, 8'h0C, 1'b0);
    cyc();
    chk_out("new nsf", 4'd10, 1'b1, 1'b0, 8'h0A, 1'b1);
    cyc();
    chk_out("to6", 4'd6, 1'b1, 1'b0, 8'h06, 1'b1);
    cyc();
    chk_out("spin6", 4'd6, 1'b1, 1'b0, 8'h06, 1'b1);

    // Reset mid-run: immediate return to idle, no done pulse.
    rst_n = 1'b0;
    #1;
    chk_out("async rst", 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc();
    chk_out("in rst", 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    cyc();
    chk_out("post rst", 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Readback: cleared word 0 is a self-loop at 0 with zero strobes.
    step_en = 1'b0; start = 1'b1; cond = 7'h01;
    cyc();
    start = 1'b0;
    chk_out("rb launch", 4'd0, 1'b1, 1'b0, 8'h00, 1'b1);
    step_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out($sformatf("rb%0d", i), 4'd0, 1'b1, 1'b0, 8'h00, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
